// File: rtl/counter.sv
// Stopwatch time base: a prescaler divides clk down to 1 ms ticks, and a chained
// ms/s/min/h counter accumulates those ticks while start_signal is high.
module counter #(
  parameter int TICKS_PER_MS = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_signal,
  output logic [3:0] hours,
  output logic [5:0] minutes,
  output logic [5:0] seconds,
  output logic [9:0] milliseconds
);

  localparam int PW = (TICKS_PER_MS > 1) ? $clog2(TICKS_PER_MS) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_MS - 1);

  logic [PW-1:0] presc;
  logic          ms_tick;
  logic          ms_wrap;
  logic          sec_wrap;
  logic          min_wrap;

  // With TICKS_PER_MS == 1 the prescaler stays at 0, so ms_tick follows start_signal.
  always_comb begin
    ms_tick  = start_signal && (presc == PRESC_LAST);
    ms_wrap  = (milliseconds == 10'd999);
    sec_wrap = (seconds == 6'd59);
    min_wrap = (minutes == 6'd59);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; blocking here would let the carry chain race within the edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      presc <= '0;
    end else if (start_signal) begin
      presc <= (presc == PRESC_LAST) ? '0 : presc + 1'b1;
    end
  end

  // The whole carry chain is evaluated from the current values, so a rollover
  // such as 0:59:59.999 -> 1:00:00.000 lands in a single edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hours        <= '0;
      minutes      <= '0;
      seconds      <= '0;
      milliseconds <= '0;
    end else if (ms_tick) begin
      if (!ms_wrap) begin
        milliseconds <= milliseconds + 10'd1;
      end else begin
        milliseconds <= '0;
        if (!sec_wrap) begin
          seconds <= seconds + 6'd1;
        end else begin
          seconds <= '0;
          if (!min_wrap) begin
            minutes <= minutes + 6'd1;
          end else begin
            minutes <= '0;
            hours   <= hours + 4'd1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_counter.sv
// Directed bench for the stopwatch counter: long runs, pause/hold, async reset,
// carry-chain corners preset by force, and prescaler phase with TICKS_PER_MS=4.
module tb_counter;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start1 = 1'b0;
  logic       start4 = 1'b0;
  logic [3:0] h1, h4;
  logic [5:0] m1, m4, s1, s4;
  logic [9:0] ms1, ms4;
  int         total = 0;
  int         bad = 0;

  always #5 clk = ~clk;

  counter #(.TICKS_PER_MS(1)) dut (
    .clk(clk), .reset(reset), .start_signal(start1),
    .hours(h1), .minutes(m1), .seconds(s1), .milliseconds(ms1)
  );

  counter #(.TICKS_PER_MS(4)) dut4 (
    .clk(clk), .reset(reset), .start_signal(start4),
    .hours(h4), .minutes(m4), .seconds(s4), .milliseconds(ms4)
  );

  // Decimal encoding hMMSSmmm, e.g. 1:02:03.004 -> 10203004.
  function automatic int enc(input int h, input int m, input int s, input int ms);
    return h * 10_000_000 + m * 100_000 + s * 1000 + ms;
  endfunction

  function automatic int t1();
    return enc(int'(h1), int'(m1), int'(s1), int'(ms1));
  endfunction

  function automatic int t4();
    return enc(int'(h4), int'(m4), int'(s4), int'(ms4));
  endfunction

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic run1(input int n);
    start1 = 1'b1;
    repeat (n) @(negedge clk);
    start1 = 1'b0;
  endtask

  // Preset dut while it is paused, then apply exactly one ms tick.
  task automatic preset_tick(input int h, input int m, input int s, input int ms);
    force dut.hours        = 4'(h);
    force dut.minutes      = 6'(m);
    force dut.seconds      = 6'(s);
    force dut.milliseconds = 10'(ms);
    #1;
    release dut.hours;
    release dut.minutes;
    release dut.seconds;
    release dut.milliseconds;
    @(negedge clk);
    run1(1);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("reset_dut1", t1(), 0);
    check("reset_dut4", t4(), 0);

    // Run from reset: 61000 ticks crosses the first minute boundary.
    reset = 1'b1;
    run1(61000);
    check("run_61000", t1(), enc(0, 1, 1, 0));

    // Paused: everything must hold.
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (i % 100 == 0) check("pause_hold", t1(), enc(0, 1, 1, 0));
    end
    run1(2500);
    check("resume_2500", t1(), enc(0, 1, 3, 500));

    // Short async reset pulse between edges while running.
    start1 = 1'b1;
    @(posedge clk);
    #2 reset = 1'b0;
    #1 check("async_reset", t1(), 0);
    #1 reset = 1'b1;
    @(negedge clk);
    check("after_release", t1(), 0);
    repeat (3000) @(negedge clk);
    start1 = 1'b0;
    check("restart_3000", t1(), enc(0, 0, 3, 0));

    // Carry-chain corners, one tick each.
    preset_tick(0, 59, 59, 999);
    check("carry_to_hour", t1(), enc(1, 0, 0, 0));
    preset_tick(0, 5, 17, 999);
    check("ms_to_sec", t1(), enc(0, 5, 18, 0));
    preset_tick(2, 7, 59, 999);
    check("sec_to_min", t1(), enc(2, 8, 0, 0));
    preset_tick(3, 59, 59, 998);
    check("no_early_carry", t1(), enc(3, 59, 59, 999));
    preset_tick(15, 59, 59, 999);
    check("hours_wrap", t1(), 0);
    run1(2);
    check("after_wrap", t1(), enc(0, 0, 0, 2));

    // Prescaler by 4: ticks on every 4th enabled edge.
    start4 = 1'b1;
    repeat (10) @(negedge clk);
    check("presc_10", t4(), 2);
    repeat (2) @(negedge clk);
    check("presc_12", t4(), 3);
    start4 = 1'b0;
    repeat (7) @(negedge clk);
    check("presc_pause", t4(), 3);
    start4 = 1'b1;
    repeat (2) @(negedge clk);
    check("presc_resume2", t4(), 3);
    @(negedge clk);
    check("presc_resume3", t4(), 3);
    @(negedge clk);
    start4 = 1'b0;
    check("presc_resume4", t4(), 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
